// File: rtl/fir_seq_pkg.sv
// Shared types and default widths for the FIR batch sequencer.
// The state enum is also exported on the top-level debug port.
package fir_seq_pkg;

    localparam int DEF_CNT_W = 16;
    localparam int DEF_LAT_W = 20;
    localparam int DEF_TO_W  = 24;

    localparam logic [DEF_LAT_W-1:0] LAT_SAT = '1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        GAP   = 3'd3,
        FIN   = 3'd4,
        ERR   = 3'd5
    } fir_seq_state_e;

endpackage

// File: rtl/fir_lat_stats.sv
// Saturating per-frame latency counter with last/min/max capture registers.
// start reloads the counter to 1, so the first ISSUE cycle already counts as one.
module fir_lat_stats #(
    parameter int LAT_W = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             start,
    input  logic             capture,
    output logic [LAT_W-1:0] lat_last,
    output logic [LAT_W-1:0] lat_min,
    output logic [LAT_W-1:0] lat_max
);
    localparam logic [LAT_W-1:0] SAT = '1;

    logic [LAT_W-1:0] cnt_q, cnt_d;
    logic [LAT_W-1:0] last_q, last_d;
    logic [LAT_W-1:0] min_q, min_d;
    logic [LAT_W-1:0] max_q, max_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            last_q <= '0;
            min_q  <= SAT;
            max_q  <= '0;
        end else begin
            cnt_q  <= cnt_d;
            last_q <= last_d;
            min_q  <= min_d;
            max_q  <= max_d;
        end
    end

    always_comb begin
        cnt_d  = cnt_q;
        last_d = last_q;
        min_d  = min_q;
        max_d  = max_q;
        // A capture on the same edge as start still sees the finishing frame's count.
        if (start) begin
            cnt_d = LAT_W'(1);
        end else if (clear) begin
            cnt_d = '0;
        end else if (cnt_q != SAT) begin
            cnt_d = cnt_q + LAT_W'(1);
        end
        if (clear) begin
            last_d = '0;
            min_d  = SAT;
            max_d  = '0;
        end else if (capture) begin
            last_d = cnt_q;
            min_d  = (cnt_q < min_q) ? cnt_q : min_q;
            max_d  = (cnt_q > max_q) ? cnt_q : max_q;
        end
    end

    assign lat_last = last_q;
    assign lat_min  = min_q;
    assign lat_max  = max_q;

endmodule

// File: rtl/fir_batch_sequencer.sv
// Issues batches of ap_ctrl_hs transactions to the FIR core with gap, stop,
// per-frame watchdog and latency statistics.
module fir_batch_sequencer
    import fir_seq_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W,
    parameter int LAT_W = DEF_LAT_W,
    parameter int TO_W  = DEF_TO_W
) (
    input  logic             ap_clk,
    input  logic             ap_rst_n,
    input  logic             cmd_start,
    input  logic             cmd_stop,
    input  logic [CNT_W-1:0] cfg_num_frames,
    input  logic [LAT_W-1:0] cfg_gap,
    input  logic [TO_W-1:0]  cfg_timeout,
    output logic             core_start,
    input  logic             core_ready,
    input  logic             core_done,
    input  logic             core_idle,
    output logic             busy,
    output logic             batch_done,
    output logic             err_timeout,
    output logic [CNT_W-1:0] frames_done,
    output logic [LAT_W-1:0] lat_last,
    output logic [LAT_W-1:0] lat_min,
    output logic [LAT_W-1:0] lat_max,
    output fir_seq_state_e   dbg_state
);
    fir_seq_state_e   state_q, state_d, after_done;
    logic [CNT_W-1:0] frames_done_q, frames_done_d, num_q, num_d;
    logic [LAT_W-1:0] gap_q, gap_d, gap_cnt_q, gap_cnt_d;
    logic [TO_W-1:0]  to_q, to_d, wd_q, wd_d;
    logic             stop_q, stop_d, batch_done_q, batch_done_d, err_q, err_d;
    logic             accept, in_frame, done_ev, timeout_hit, frame_last, start_frame;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        accept      = cmd_start && core_idle && (state_q == IDLE || state_q == ERR);
        in_frame    = (state_q == ISSUE) || (state_q == WAIT);
        // Completion in ISSUE only counts once the core has also taken the start.
        done_ev     = core_done && ((state_q == WAIT) || (state_q == ISSUE && core_ready));
        timeout_hit = (to_q != '0) && (wd_q == to_q);
        frame_last  = (num_q != '0) && (frames_done_q + CNT_W'(1) == num_q);
        if (frame_last || stop_q || cmd_stop) begin
            after_done = FIN;
        end else if (gap_q != '0) begin
            after_done = GAP;
        end else begin
            after_done = ISSUE;
        end
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = ISSUE;
            ISSUE: begin
                if (done_ev)          state_d = after_done;
                else if (timeout_hit) state_d = ERR;
                else if (core_ready)  state_d = WAIT;
            end
            WAIT: begin
                if (done_ev)          state_d = after_done;
                else if (timeout_hit) state_d = ERR;
            end
            GAP:     if (gap_cnt_q <= LAT_W'(1)) state_d = ISSUE;
            FIN:     state_d = IDLE;
            ERR:     if (accept) state_d = ISSUE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        core_start  = (state_q == ISSUE);
        busy        = (state_q == ISSUE) || (state_q == WAIT) || (state_q == GAP);
        dbg_state   = state_q;
        batch_done  = batch_done_q;
        err_timeout = err_q;
        frames_done = frames_done_q;
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            frames_done_q <= '0;
            num_q         <= '0;
            gap_q         <= '0;
            gap_cnt_q     <= '0;
            to_q          <= '0;
            wd_q          <= '0;
            stop_q        <= 1'b0;
            batch_done_q  <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            frames_done_q <= frames_done_d;
            num_q         <= num_d;
            gap_q         <= gap_d;
            gap_cnt_q     <= gap_cnt_d;
            to_q          <= to_d;
            wd_q          <= wd_d;
            stop_q        <= stop_d;
            batch_done_q  <= batch_done_d;
            err_q         <= err_d;
        end
    end

    always_comb begin
        start_frame   = (state_d == ISSUE) && ((state_q != ISSUE) || done_ev);
        num_d         = accept ? cfg_num_frames : num_q;
        gap_d         = accept ? cfg_gap : gap_q;
        to_d          = accept ? cfg_timeout : to_q;
        frames_done_d = frames_done_q;
        if (accept)       frames_done_d = '0;
        else if (done_ev) frames_done_d = frames_done_q + CNT_W'(1);
        wd_d = wd_q;
        if (start_frame)   wd_d = TO_W'(1);
        else if (in_frame) wd_d = wd_q + TO_W'(1);
        gap_cnt_d = gap_cnt_q;
        if (done_ev)               gap_cnt_d = gap_q;
        else if (state_q == GAP)   gap_cnt_d = gap_cnt_q - LAT_W'(1);
        stop_d = stop_q;
        if (accept || state_q == FIN) stop_d = 1'b0;
        else if (cmd_stop && busy)    stop_d = 1'b1;
        batch_done_d = batch_done_q;
        if (accept)              batch_done_d = 1'b0;
        else if (state_d == FIN) batch_done_d = 1'b1;
        err_d = err_q;
        if (accept)              err_d = 1'b0;
        else if (state_d == ERR) err_d = 1'b1;
    end

    fir_lat_stats #(
        .LAT_W (LAT_W)
    ) u_lat_stats (
        .clk      (ap_clk),
        .rst_n    (ap_rst_n),
        .clear    (accept),
        .start    (start_frame),
        .capture  (done_ev),
        .lat_last (lat_last),
        .lat_min  (lat_min),
        .lat_max  (lat_max)
    );

endmodule

// File: tb/tb_fir_batch_sequencer.sv
// Bench for fir_batch_sequencer: a behavioural ap_ctrl_hs core plus a batch-level
// reference model of frame counts, start spacing and latency statistics.
module tb_fir_batch_sequencer;
    import fir_seq_pkg::*;

    localparam int CNT_W = DEF_CNT_W;
    localparam int LAT_W = DEF_LAT_W;
    localparam int TO_W  = DEF_TO_W;

    logic             ap_clk = 1'b0;
    logic             ap_rst_n = 1'b0;
    logic             cmd_start = 1'b0;
    logic             cmd_stop = 1'b0;
    logic [CNT_W-1:0] cfg_num_frames = '0;
    logic [LAT_W-1:0] cfg_gap = '0;
    logic [TO_W-1:0]  cfg_timeout = '0;
    logic             core_start;
    logic             core_ready = 1'b0;
    logic             core_done = 1'b0;
    logic             core_idle = 1'b1;
    logic             busy, batch_done, err_timeout;
    logic [CNT_W-1:0] frames_done;
    logic [LAT_W-1:0] lat_last, lat_min, lat_max;
    fir_seq_state_e   dbg_state;

    fir_batch_sequencer dut (
        .ap_clk         (ap_clk),
        .ap_rst_n       (ap_rst_n),
        .cmd_start      (cmd_start),
        .cmd_stop       (cmd_stop),
        .cfg_num_frames (cfg_num_frames),
        .cfg_gap        (cfg_gap),
        .cfg_timeout    (cfg_timeout),
        .core_start     (core_start),
        .core_ready     (core_ready),
        .core_done      (core_done),
        .core_idle      (core_idle),
        .busy           (busy),
        .batch_done     (batch_done),
        .err_timeout    (err_timeout),
        .frames_done    (frames_done),
        .lat_last       (lat_last),
        .lat_min        (lat_min),
        .lat_max        (lat_max),
        .dbg_state      (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 ap_clk = ~ap_clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    // ---------------- scoreboard state ----------------
    int errors = 0;
    int checks = 0;
    logic [LAT_W-1:0] exp_q[$];     // expected latency of every frame the core started
    int rdy_q[$], dn_q[$];          // planned ready/done offsets per frame
    int model_lat[$];               // batch-level model: latency of each planned frame
    int start_cyc[$], done_cyc[$], err_cyc[$];
    int cyc = 0, starts = 0, wait_seen = 0;
    int stop_frame = -1, stop_mode = 0;
    logic active = 1'b0;
    int t = 0, r_off = 0, d_off = 0;
    logic prev_start = 0, prev_ready = 0, prev_done = 0, prev_busy = 0, prev_err = 0;
    logic [LAT_W-1:0] lat_e;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Behavioural core plus monitor; everything sampled mid-cycle.
    always @(negedge ap_clk) begin
        cyc++;
        if (!ap_rst_n) begin
            active = 0; core_ready = 0; core_done = 0; core_idle = 1; cmd_stop = 0;
            prev_start = 0; prev_ready = 0; prev_done = 0; prev_busy = 0; prev_err = 0;
            exp_q.delete();
        end else begin
            if (prev_done && exp_q.size() > 0) begin
                lat_e = exp_q.pop_front();
                if (prev_busy) check_eq("lat_last_frame", 32'(lat_last), 32'(lat_e));
            end
            if (prev_start && !core_start && !err_timeout)
                check_eq("start_held_until_ready", 32'(prev_ready), 32'd1);
            if (err_timeout && !prev_err) err_cyc.push_back(cyc);
            if (dbg_state == WAIT) wait_seen++;
            if (active) begin
                if (t == d_off) active = 0;
                else t++;
            end
            if (!active && core_start) begin
                active = 1; t = 0; starts++;
                start_cyc.push_back(cyc);
                if (rdy_q.size() > 0) begin
                    r_off = rdy_q.pop_front();
                    d_off = dn_q.pop_front();
                end else begin
                    r_off = 1; d_off = 3;
                end
                exp_q.push_back(LAT_W'(d_off + 1));
            end
            core_ready = active && (t == r_off);
            core_done  = active && (t == d_off);
            if (core_done) done_cyc.push_back(cyc);
            core_idle  = !active;
            cmd_stop   = active && (starts == stop_frame) &&
                         ((stop_mode == 1 && t == 1) || (stop_mode == 2 && core_done));
            prev_start = core_start; prev_ready = core_ready; prev_done = core_done;
            prev_busy  = busy; prev_err = err_timeout;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic plan_frame(input int r, input int d);
        rdy_q.push_back(r);
        dn_q.push_back(d);
        model_lat.push_back(d + 1);
    endtask

    task automatic start_batch(input int nf, input int gap, input int to);
        @(negedge ap_clk);
        cfg_num_frames = CNT_W'(nf);
        cfg_gap        = LAT_W'(gap);
        cfg_timeout    = TO_W'(to);
        cmd_start      = 1'b1;
        @(negedge ap_clk);
        cmd_start      = 1'b0;
    endtask

    task automatic wait_end(input string tag);
        int n = 0;
        while (!(batch_done || err_timeout) && n < 2000) begin
            @(negedge ap_clk);
            n++;
        end
        check_eq({tag, "_batch_ended"}, 32'(n < 2000), 32'd1);
        @(negedge ap_clk);
    endtask

    task automatic check_reset(input string tag);
        check_eq({tag, "_core_start"}, 32'(core_start), 32'd0);
        check_eq({tag, "_busy"}, 32'(busy), 32'd0);
        check_eq({tag, "_batch_done"}, 32'(batch_done), 32'd0);
        check_eq({tag, "_err"}, 32'(err_timeout), 32'd0);
        check_eq({tag, "_frames"}, 32'(frames_done), 32'd0);
        check_eq({tag, "_lat_last"}, 32'(lat_last), 32'd0);
        check_eq({tag, "_lat_min"}, 32'(lat_min), 32'h000F_FFFF);
        check_eq({tag, "_lat_max"}, 32'(lat_max), 32'd0);
    endtask

    // Batch-end check against the model: frames = n, stats over the first n planned frames.
    task automatic check_batch(input string tag, input int n);
        int mn = 32'h7FFF_FFFF, mx = 0;
        for (int i = 0; i < n; i++) begin
            if (model_lat[i] < mn) mn = model_lat[i];
            if (model_lat[i] > mx) mx = model_lat[i];
        end
        check_eq({tag, "_frames"}, 32'(frames_done), 32'(n));
        check_eq({tag, "_batch_done"}, 32'(batch_done), 32'd1);
        check_eq({tag, "_busy"}, 32'(busy), 32'd0);
        check_eq({tag, "_core_start"}, 32'(core_start), 32'd0);
        check_eq({tag, "_err"}, 32'(err_timeout), 32'd0);
        check_eq({tag, "_lat_last"}, 32'(lat_last), 32'(model_lat[n-1]));
        check_eq({tag, "_lat_min"}, 32'(lat_min), 32'(mn));
        check_eq({tag, "_lat_max"}, 32'(lat_max), 32'(mx));
        model_lat.delete();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int s0, d0, e0, w0, n, nf, gap;
        repeat (3) @(negedge ap_clk);
        check_reset("reset");
        ap_rst_n = 1'b1;
        repeat (2) @(negedge ap_clk);

        // Three frames, ready at +2, latency 10, no gap.
        repeat (3) plan_frame(2, 9);
        s0 = start_cyc.size(); d0 = done_cyc.size();
        start_batch(3, 0, 0);
        wait_end("b3");
        check_eq("b3_start_pulses", 32'(start_cyc.size() - s0), 32'd3);
        check_eq("b3_rerise_after_done", 32'(start_cyc[s0+1] - done_cyc[d0]), 32'd1);
        check_batch("b3", 3);

        // Gap of 5: next start six cycles after the first done.
        plan_frame(1, 4); plan_frame(1, 4);
        s0 = start_cyc.size(); d0 = done_cyc.size();
        start_batch(2, 5, 0);
        wait_end("gap5");
        check_eq("gap5_rerise", 32'(start_cyc[s0+1] - done_cyc[d0]), 32'd6);
        check_batch("gap5", 2);

        // Latencies 7, 12, 9.
        plan_frame(2, 6); plan_frame(3, 11); plan_frame(1, 8);
        start_batch(3, 1, 0);
        wait_end("stats");
        check_batch("stats", 3);

        // Watchdog: done never arrives within the limit.
        plan_frame(2, 200);
        s0 = start_cyc.size(); e0 = err_cyc.size();
        start_batch(1, 0, 20);
        n = 0;
        while (!err_timeout && n < 100) begin @(negedge ap_clk); n++; end
        @(negedge ap_clk);
        check_eq("to_err_seen", 32'(err_cyc.size() - e0), 32'd1);
        if (err_cyc.size() > e0)
            check_eq("to_cycles", 32'(err_cyc[e0] - start_cyc[s0]), 32'd20);
        check_eq("to_err", 32'(err_timeout), 32'd1);
        check_eq("to_core_start", 32'(core_start), 32'd0);
        check_eq("to_busy", 32'(busy), 32'd0);
        check_eq("to_batch_done", 32'(batch_done), 32'd0);
        check_eq("to_frames", 32'(frames_done), 32'd0);
        model_lat.delete();
        n = 0;
        while (!core_idle && n < 400) begin @(negedge ap_clk); n++; end
        plan_frame(0, 5);
        start_batch(1, 0, 20);
        check_eq("to_err_cleared", 32'(err_timeout), 32'd0);
        wait_end("to_retry");
        check_batch("to_retry", 1);

        // Run-until-stopped, stop pulsed while frame 4 still waits for ready.
        for (int k = 0; k < 4; k++) plan_frame(3, 6);
        stop_frame = starts + 4; stop_mode = 1;
        start_batch(0, 1, 0);
        wait_end("stop_mid");
        check_batch("stop_mid", 4);

        // Stop coincident with done of frame 4.
        for (int k = 0; k < 4; k++) plan_frame(1, 5);
        stop_frame = starts + 4; stop_mode = 2;
        start_batch(0, 0, 0);
        wait_end("stop_done");
        check_batch("stop_done", 4);
        stop_mode = 0;

        // Ready and done on the very first ISSUE cycle.
        plan_frame(0, 0);
        s0 = start_cyc.size(); d0 = done_cyc.size(); w0 = wait_seen;
        start_batch(1, 0, 0);
        wait_end("instant");
        check_eq("instant_same_cycle", 32'(done_cyc[d0] - start_cyc[s0]), 32'd0);
        check_eq("instant_no_wait", 32'(wait_seen - w0), 32'd0);
        check_batch("instant", 1);

        // Randomised batches checked against the model.
        for (int b = 0; b < 6; b++) begin
            nf  = $urandom_range(1, 4);
            gap = $urandom_range(0, 3);
            for (int k = 0; k < nf; k++) begin
                d0 = $urandom_range(0, 12);
                plan_frame($urandom_range(0, d0), d0);
            end
            s0 = start_cyc.size(); d0 = done_cyc.size();
            start_batch(nf, gap, 100);
            wait_end("rand");
            for (int k = 0; k + 1 < nf; k++)
                check_eq("rand_spacing", 32'(start_cyc[s0+k+1] - done_cyc[d0+k]), 32'(gap + 1));
            check_batch("rand", nf);
        end

        // Reset asserted while frame 2 sits in WAIT.
        plan_frame(1, 4); plan_frame(1, 40);
        start_batch(2, 2, 0);
        n = 0;
        while (frames_done != 1 && n < 200) begin @(negedge ap_clk); n++; end
        repeat (6) @(negedge ap_clk);
        check_eq("pre_reset_in_wait", 32'(dbg_state), 32'(WAIT));
        #2 ap_rst_n = 1'b0;
        #1 check_reset("reset_in_wait");
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        model_lat.delete();
        repeat (2) @(negedge ap_clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
